i2s_tx_feeder: RTL and testbench

I2S_TX_FEEDER -- requirements
Module: i2s_tx_feeder

---
 rtl/i2s_pkg.sv | 19 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/i2s_tx_feeder.sv | 129 ++++++++++++
 tb/tb_i2s_tx_feeder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared types and defaults for the I2S transmit feeder. Rev 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

   localparam int unsigned c_DATA_WIDTH = 16;
   // Widest legal sample; the pair struct is sized for it so any width fits.
   localparam int unsigned c_MAX_WIDTH  = 24;

   typedef struct packed {
      logic [c_MAX_WIDTH-1:0] left;
      logic [c_MAX_WIDTH-1:0] right;
   } stereo_pair_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock show-ahead FIFO with level count. Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_level;
   logic             w_wr;
   logic             w_rd;

   assign w_wr = i_wr_en & ~o_full;
   assign w_rd = i_rd_en & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + (c_AW+1)'(1);
            2'b01:   r_level <= r_level - (c_AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = (r_level == (c_AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_feeder.sv
// ============================================================================
// i2s_tx_feeder : buffers stereo pairs and hands them to an I2S controller
// on LRCLK edges. Rev 1.0
// ============================================================================
`default_nettype none

module i2s_tx_feeder
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                       CLK_I,
   input  logic                       RST_I,
   input  logic                       EN_I,
   input  logic                       S_VALID_I,
   output logic                       S_READY_O,
   input  logic [DATA_WIDTH-1:0]      S_L_I,
   input  logic [DATA_WIDTH-1:0]      S_R_I,
   input  logic                       LRCLK_I,
   output logic [DATA_WIDTH-1:0]      D_L_O,
   output logic [DATA_WIDTH-1:0]      D_R_O,
   output logic [$clog2(DEPTH):0]     LEVEL_O,
   output logic                       UNDERRUN_O,
   input  logic                       UNDERRUN_CLR_I
);

   localparam int unsigned c_LW = $clog2(DEPTH) + 1;

   logic                    r_lrclk_prev;
   logic                    r_ready;
   logic [DATA_WIDTH-1:0]   r_dl;
   logic [DATA_WIDTH-1:0]   r_dr;
   logic [DATA_WIDTH-1:0]   r_stage;
   logic                    r_underrun;

   logic                    w_push;
   logic                    w_rise;
   logic                    w_fall;
   logic                    w_pop;
   logic                    w_underrun_set;
   logic                    w_full;
   logic                    w_empty;
   logic [c_LW-1:0]         w_level;
   logic [c_LW-1:0]         w_level_nxt;
   logic [2*DATA_WIDTH-1:0] w_rd_data;
   stereo_pair_t            w_rd_pair;
   logic                    w_unused;

   assign w_push = S_VALID_I & r_ready & ~w_full;
   assign w_rise = LRCLK_I & ~r_lrclk_prev;
   assign w_fall = ~LRCLK_I & r_lrclk_prev;
   // Emptiness comes from the stored level, so a same-cycle push cannot fall through.
   assign w_pop          = w_rise & EN_I & ~w_empty;
   assign w_underrun_set = w_rise & EN_I & w_empty;

   sync_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK_I),
      .rst       (RST_I),
      .i_wr_en   (w_push),
      .i_wr_data ({S_L_I, S_R_I}),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (w_level)
   );

   always_comb begin
      w_rd_pair       = '0;
      w_rd_pair.left  = c_MAX_WIDTH'(w_rd_data[2*DATA_WIDTH-1 -: DATA_WIDTH]);
      w_rd_pair.right = c_MAX_WIDTH'(w_rd_data[DATA_WIDTH-1:0]);
   end

   assign w_unused = ^w_rd_pair;

   always_comb begin
      w_level_nxt = w_level;
      if (w_push && !w_pop) begin
         w_level_nxt = w_level + c_LW'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = w_level - c_LW'(1);
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_lrclk_prev <= 1'b0;
         r_ready      <= 1'b0;
         r_dl         <= '0;
         r_dr         <= '0;
         r_stage      <= '0;
         r_underrun   <= 1'b0;
      end else begin
         r_lrclk_prev <= LRCLK_I;
         r_ready      <= (w_level_nxt != c_LW'(DEPTH));
         if (!EN_I) begin
            r_dl    <= '0;
            r_dr    <= '0;
            r_stage <= '0;
         end else begin
            if (w_rise) begin
               r_dl    <= w_pop ? w_rd_pair.left[DATA_WIDTH-1:0]  : '0;
               r_stage <= w_pop ? w_rd_pair.right[DATA_WIDTH-1:0] : '0;
            end
            if (w_fall) begin
               r_dr <= r_stage;
            end
         end
         if (UNDERRUN_CLR_I) begin
            r_underrun <= 1'b0;
         end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign S_READY_O  = r_ready;
   assign D_L_O      = r_dl;
   assign D_R_O      = r_dr;
   assign LEVEL_O    = w_level;
   assign UNDERRUN_O = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_feeder.sv
// ============================================================================
// tb_i2s_tx_feeder : directed vector table plus hand-written corner sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2s_tx_feeder;

   localparam int unsigned c_DW    = 16;
   localparam int unsigned c_DEPTH = 16;

   logic            clk;
   logic            rst;
   logic            en;
   logic            valid;
   logic            ready;
   logic [15:0]     sl;
   logic [15:0]     sr;
   logic            lrclk;
   logic [15:0]     dl;
   logic [15:0]     dr;
   logic [4:0]      level;
   logic            und;
   logic            clr;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic        valid;
      logic [15:0] l;
      logic [15:0] r;
      logic        lrclk;
      logic        clr;
      logic        ready;
      logic [15:0] dl;
      logic [15:0] dr;
      logic [4:0]  lvl;
      logic        und;
   } vec_t;

   vec_t vecs [17];

   i2s_tx_feeder #(
      .DATA_WIDTH (c_DW),
      .DEPTH      (c_DEPTH)
   ) dut (
      .CLK_I          (clk),
      .RST_I          (rst),
      .EN_I           (en),
      .S_VALID_I      (valid),
      .S_READY_O      (ready),
      .S_L_I          (sl),
      .S_R_I          (sr),
      .LRCLK_I        (lrclk),
      .D_L_O          (dl),
      .D_R_O          (dr),
      .LEVEL_O        (level),
      .UNDERRUN_O     (und),
      .UNDERRUN_CLR_I (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic r_, logic e_, logic v_, logic [15:0] l_, logic [15:0] rr_,
                               logic lr_, logic c_, logic rdy_, logic [15:0] dl_,
                               logic [15:0] dr_, logic [4:0] lv_, logic u_);
      vec_t v;
      v.rst = r_; v.en = e_; v.valid = v_; v.l = l_; v.r = rr_; v.lrclk = lr_; v.clr = c_;
      v.ready = rdy_; v.dl = dl_; v.dr = dr_; v.lvl = lv_; v.und = u_;
      return v;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; valid = 1'b0; sl = '0; sr = '0; lrclk = 1'b0; clr = 1'b0;

      //                rst en vld  L         R         lr clr  rdy DL        DR        lvl und
      vecs[0]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0000, 16'h0000, 0, 0);
      vecs[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0000, 16'h0000, 0, 0);
      vecs[2]  = mk(0, 0, 1, 16'h1111, 16'hA001, 0, 0,   1, 16'h0000, 16'h0000, 1, 0);
      vecs[3]  = mk(0, 0, 1, 16'h2222, 16'hA002, 0, 0,   1, 16'h0000, 16'h0000, 2, 0);
      vecs[4]  = mk(0, 0, 1, 16'h3333, 16'hA003, 0, 0,   1, 16'h0000, 16'h0000, 3, 0);
      vecs[5]  = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0000, 16'h0000, 3, 0);
      vecs[6]  = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0,   1, 16'h1111, 16'h0000, 2, 0);
      vecs[7]  = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0,   1, 16'h1111, 16'h0000, 2, 0);
      vecs[8]  = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h1111, 16'hA001, 2, 0);
      vecs[9]  = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0,   1, 16'h2222, 16'hA001, 1, 0);
      vecs[10] = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h2222, 16'hA002, 1, 0);
      vecs[11] = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0,   1, 16'h3333, 16'hA002, 0, 0);
      vecs[12] = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h3333, 16'hA003, 0, 0);
      vecs[13] = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0,   1, 16'h0000, 16'hA003, 0, 1);
      vecs[14] = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 1,   1, 16'h0000, 16'hA003, 0, 0);
      vecs[15] = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0000, 16'h0000, 0, 0);
      vecs[16] = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 1,   1, 16'h0000, 16'h0000, 0, 0);

      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst; en = vecs[i].en; valid = vecs[i].valid;
         sl = vecs[i].l; sr = vecs[i].r; lrclk = vecs[i].lrclk; clr = vecs[i].clr;
         step();
         chk($sformatf("v%0d.ready", i), 32'(ready), 32'(vecs[i].ready));
         chk($sformatf("v%0d.dl", i),    32'(dl),    32'(vecs[i].dl));
         chk($sformatf("v%0d.dr", i),    32'(dr),    32'(vecs[i].dr));
         chk($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].lvl));
         chk($sformatf("v%0d.und", i),   32'(und),   32'(vecs[i].und));
      end
      clr = 1'b0; valid = 1'b0;

      // Fill to full with no LRCLK edges, then one rise frees a slot.
      lrclk = 1'b0; step();
      for (int i = 0; i < 16; i++) begin
         valid = 1'b1; sl = 16'h0100 + 16'(i); sr = 16'h0200 + 16'(i);
         step();
      end
      chk("fill.ready", 32'(ready), 32'd0);
      chk("fill.level", 32'(level), 32'd16);
      sl = 16'hDEAD; sr = 16'hBEEF; step();
      chk("full_push.level", 32'(level), 32'd16);
      valid = 1'b0; lrclk = 1'b1; step();
      chk("fill_pop.level", 32'(level), 32'd15);
      chk("fill_pop.ready", 32'(ready), 32'd1);
      chk("fill_pop.dl",    32'(dl),    32'h0100);
      lrclk = 1'b0; step();
      chk("fill_pop.dr",    32'(dr),    32'h0200);
      // Simultaneous push and pop; the push lands at the wrapped write pointer.
      valid = 1'b1; sl = 16'h01AA; sr = 16'h02AA; lrclk = 1'b1; step();
      chk("pushpop.level",  32'(level), 32'd15);
      chk("pushpop.dl",     32'(dl),    32'h0101);
      valid = 1'b0;
      for (int k = 2; k < 16; k++) begin
         lrclk = 1'b0; step();
         lrclk = 1'b1; step();
         chk($sformatf("drain%0d.dl", k), 32'(dl), 32'h0100 + 32'(k));
      end
      lrclk = 1'b0; step();
      lrclk = 1'b1; step();
      chk("wrap.dl",    32'(dl),    32'h01AA);
      chk("wrap.level", 32'(level), 32'd0);
      lrclk = 1'b0; step();
      chk("wrap.dr",    32'(dr),    32'h02AA);

      // Push in the rise cycle on an empty FIFO is an underrun, not a fall-through.
      valid = 1'b1; sl = 16'h5555; sr = 16'h6666; lrclk = 1'b1; step();
      chk("same.dl",    32'(dl),    32'h0000);
      chk("same.und",   32'(und),   32'd1);
      chk("same.level", 32'(level), 32'd1);
      valid = 1'b0; lrclk = 1'b0; step();
      chk("same.dr0",   32'(dr),    32'h0000);
      lrclk = 1'b1; step();
      chk("same.dl2",   32'(dl),    32'h5555);
      chk("same.lvl2",  32'(level), 32'd0);
      lrclk = 1'b0; step();
      chk("same.dr2",   32'(dr),    32'h6666);

      // Disabled playback keeps contents and zeroes outputs.
      clr = 1'b1; step(); clr = 1'b0;
      chk("clr.und", 32'(und), 32'd0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1; sl = 16'h0A00 + 16'(i); sr = 16'h0B00 + 16'(i);
         lrclk = i[0];
         step();
      end
      valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lrclk = ~lrclk; step();
         chk($sformatf("dis%0d.dl", i),    32'(dl),    32'h0000);
         chk($sformatf("dis%0d.dr", i),    32'(dr),    32'h0000);
         chk($sformatf("dis%0d.level", i), 32'(level), 32'd5);
      end
      en = 1'b1; lrclk = 1'b1; step();
      chk("reen.dl",    32'(dl),    32'h0A00);
      chk("reen.level", 32'(level), 32'd4);
      lrclk = 1'b0; step();
      chk("reen.dr",    32'(dr),    32'h0B00);

      // Reset mid-stream drops everything; the next rise underruns.
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; sl = 16'h0C00 + 16'(i); sr = 16'h0D00 + 16'(i);
         step();
      end
      valid = 1'b0;
      chk("pre_rst.level", 32'(level), 32'd7);
      rst = 1'b1; step();
      chk("rst.ready", 32'(ready), 32'd0);
      chk("rst.dl",    32'(dl),    32'h0000);
      chk("rst.dr",    32'(dr),    32'h0000);
      chk("rst.level", 32'(level), 32'd0);
      chk("rst.und",   32'(und),   32'd0);
      rst = 1'b0; step();
      chk("post_rst.ready", 32'(ready), 32'd1);
      lrclk = 1'b1; step();
      chk("post_rst.dl",    32'(dl),    32'h0000);
      chk("post_rst.und",   32'(und),   32'd1);
      chk("post_rst.level", 32'(level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
